aes_byte_serial_sched: RTL
==========================

// Module: aes_byte_serial_sched
// PURPOSE
//  Sequencer for the byte-serial AES-128 datapath: accepts a 128-bit key and block via valid/ready,
//  streams both MSB-byte-first into the key expansion and state datapath over 16 cycles, then drives
//  the per-round byte strobes and round number for rounds 1..NR. Signals last round and completion.
//  Sits between the host/AXI-lite front end and key_expansion_control plus the cipher datapath.
// PARAMETERS
//  NB_BYTES    16   bytes per block/key; byte_idx counts 0..NB_BYTES-1
//  NR          10   number of rounds (AES-128)
// PORTS
//  clk          in   1    single clock, rising edge
//  rst          in   1    synchronous, active-high reset
//  start_valid  in   1    key_in/data_in valid
//  start_ready  out  1    scheduler idle, accepts start
//  key_in       in   128  cipher key, byte 0 = key_in[127:120]
//  data_in      in   128  plaintext block, byte 0 = data_in[127:120]
//  abort        in   1    synchronous abort of current operation
//  key_byte     out  8    key byte to key expansion (valid when load_en)
//  data_byte    out  8    plaintext byte to state datapath (valid when load_en)
//  byte_idx     out  4    current byte position 0..15
//  load_en      out  1    load phase strobe
//  round_en     out  1    round phase strobe (datapath advances one byte)
//  round        out  4    current round 1..NR; 0 in IDLE/LOAD
//  last_round   out  1    high throughout round NR (MixColumns skip)
//  done         out  1    one-cycle completion pulse
//  busy         out  1    high in any state except IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; key_byte, data_byte, byte_idx, round = 0; load_en, round_en, last_round,
//    done, busy = 0. start_ready = (state==IDLE) & !rst. All outputs other than start_ready registered.
//  - FSM IDLE -> LOAD -> ROUND -> FINISH -> IDLE.
//  - IDLE: on start_valid & start_ready at edge T, capture key_in/data_in into shift regs, byte_cnt=0.
//  - LOAD (16 cycles, T+1..T+16): load_en=1, key_byte/data_byte = shift-reg [127:120], shift left 8
//    each cycle; byte_idx=byte_cnt. At byte_cnt==15: round<=1, byte_cnt<=0, -> ROUND.
//  - ROUND (NR*16 cycles): round_en=1, byte_idx 0..15 wraps; at byte 15: if round==NR -> FINISH,
//    else round<=round+1. last_round = (round==NR). key_byte/data_byte = 0 outside LOAD.
//  - FINISH: done=1 for exactly one cycle at T+177, round<=0, -> IDLE (start_ready high next cycle).
//  - Latency handshake->done: 1 + 16 + 16*NR = 177 cycles; back-to-back start accepted the cycle
//    after done (throughput 178 cycles/block).
//  - start_valid while busy: ignored (start_ready=0); inputs not sampled.
//  - abort in any non-IDLE state: next cycle state=IDLE, all outputs to reset values, no done.
//    abort in IDLE: no effect; abort & start_valid same cycle in IDLE: start wins is NOT allowed --
//    abort has priority, start not accepted.
//  - rst has priority over abort and start; rst mid-operation returns to reset values next edge.
//  - round counter 4-bit, never exceeds NR; byte_cnt 4-bit, natural wrap 15->0.
// STRUCTURE
//  - Shared header aes_params.vh: NB_BYTES, NR, AES_KEY_BITS=128, state encodings
//    (S_IDLE, S_LOAD, S_ROUND, S_FINISH) for reuse by datapath and benches.
//  - One sub-module: byte_serializer (128-bit parallel load, 8-bit MSB-first shift out, load/shift
//    enables), instantiated twice (key, data). FSM, byte_cnt and round counter live in top.
// TESTING
//  1 Reset: hold rst 3 cycles -> all outputs 0, start_ready=0 during rst, 1 the cycle after release.
//  2 Load: key=2b7e151628aed2a6abf7158809cf4f3c, data=3243f6a8885a308d313198a2e0370734 ->
//    T+1 key_byte=2b/data_byte=32, T+16 key_byte=3c/data_byte=34, load_en high exactly 16 cycles.
//  3 Full run: same stimulus -> round steps 1..10 each 16 cycles, last_round high cycles T+161..T+176,
//    done single pulse at T+177, busy low at T+178, start_ready high at T+178.
//  4 Start while busy: pulse start_valid with other key at T+50 -> ignored; key_byte stream and
//    done timing unchanged from scenario 3.
//  5 Abort: assert abort during round 4 byte 7 -> next cycle IDLE, round=0, no done; new start
//    accepted immediately and runs the full 177-cycle sequence.
//  6 Back-to-back + mid-run reset: start re-asserted continuously -> second accept at T+178;
//    rst during LOAD of second block -> all outputs 0 next cycle, no done.

Source files
------------

// File: rtl/aes_byte_serial_sched_pkg.sv
// Shared constants and state encoding for the byte-serial AES-128 scheduler.
// Reused by the scheduler, datapath and benches.
package aes_byte_serial_sched_pkg;
  localparam int NB_BYTES     = 16;
  localparam int NR           = 10;
  localparam int AES_KEY_BITS = 128;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_FINISH
  } state_t;
endpackage

// File: rtl/aes_byte_serial_sched_if.sv
// Host <-> scheduler bundle: start handshake, key/data, abort, byte stream
// and round strobes. master = host side, slave = scheduler side.
interface aes_byte_serial_sched_if;
  import aes_byte_serial_sched_pkg::*;

  logic                    start_valid;
  logic                    start_ready;
  logic [AES_KEY_BITS-1:0] key_in;
  logic [AES_KEY_BITS-1:0] data_in;
  logic                    abort;
  logic [7:0]              key_byte;
  logic [7:0]              data_byte;
  logic [3:0]              byte_idx;
  logic                    load_en;
  logic                    round_en;
  logic [3:0]              round;
  logic                    last_round;
  logic                    done;
  logic                    busy;

  modport master (
    output start_valid, key_in, data_in, abort,
    input  start_ready, key_byte, data_byte, byte_idx,
    input  load_en, round_en, round, last_round, done, busy
  );

  modport slave (
    input  start_valid, key_in, data_in, abort,
    output start_ready, key_byte, data_byte, byte_idx,
    output load_en, round_en, round, last_round, done, busy
  );
endinterface

// File: rtl/aes_byte_serial_sched_serializer.sv
// 128-bit parallel-load register shifted out MSB byte first.
// Ports: clk, rst, i_load (capture i_din), i_shift, o_byte = top byte.
module aes_byte_serial_sched_serializer
  import aes_byte_serial_sched_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_load,
  input  logic                    i_shift,
  input  logic [AES_KEY_BITS-1:0] i_din,
  output logic [7:0]              o_byte
);
  logic [AES_KEY_BITS-1:0] r_sr;

  always_ff @(posedge clk) begin
    if (rst)
      r_sr <= '0;
    else if (i_load)
      r_sr <= i_din;
    else if (i_shift)
      r_sr <= {r_sr[AES_KEY_BITS-9:0], 8'h00};
  end

  assign o_byte = r_sr[AES_KEY_BITS-1 -: 8];
endmodule

// File: rtl/aes_byte_serial_sched.sv
// Byte-serial AES-128 sequencer: load 16 key/data bytes, then NR rounds.
// Ports: clk, rst (sync, active-high), bus (slave side of the bundle).
module aes_byte_serial_sched
  import aes_byte_serial_sched_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  aes_byte_serial_sched_if.slave bus
);
  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_byte_cnt;
  logic [3:0] r_round;
  logic       w_accept;
  logic       w_abort;
  logic       w_last_byte;
  logic       w_last_rnd;
  logic [7:0] w_key_ser;
  logic [7:0] w_data_ser;

  logic [7:0] w_kb, w_db;
  logic [3:0] w_idx, w_rnd;
  logic       w_ld, w_re, w_lr, w_dn, w_bs;

  logic [7:0] r_kb, r_db;
  logic [3:0] r_idx, r_rnd;
  logic       r_ld, r_re, r_lr, r_dn, r_bs;

  assign bus.start_ready = (r_state == S_IDLE) & ~rst;
  // abort outranks a same-cycle start in IDLE
  assign w_accept    = bus.start_valid & bus.start_ready & ~bus.abort;
  assign w_abort     = bus.abort & (r_state != S_IDLE);
  assign w_last_byte = (r_byte_cnt == 4'(NB_BYTES - 1));
  assign w_last_rnd  = (r_round == 4'(NR));

  aes_byte_serial_sched_serializer u_key_ser (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_accept),
    .i_shift (r_state == S_LOAD),
    .i_din   (bus.key_in),
    .o_byte  (w_key_ser)
  );

  aes_byte_serial_sched_serializer u_data_ser (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_accept),
    .i_shift (r_state == S_LOAD),
    .i_din   (bus.data_in),
    .o_byte  (w_data_ser)
  );

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:   if (w_accept) w_next = S_LOAD;
        S_LOAD:   if (w_last_byte) w_next = S_ROUND;
        S_ROUND:  if (w_last_byte && w_last_rnd) w_next = S_FINISH;
        S_FINISH: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_abort) begin
      r_byte_cnt <= '0;
      r_round    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_byte_cnt <= '0;
          r_round    <= '0;
        end
        S_LOAD: begin
          r_byte_cnt <= r_byte_cnt + 4'd1;
          if (w_last_byte) r_round <= 4'd1;
        end
        S_ROUND: begin
          r_byte_cnt <= r_byte_cnt + 4'd1;
          if (w_last_byte && !w_last_rnd)
            r_round <= r_round + 4'd1;
        end
        S_FINISH: r_round <= '0;
      endcase
    end
  end

  // next values of the registered outputs, decoded from the current state
  always_comb begin
    w_kb  = '0;
    w_db  = '0;
    w_idx = '0;
    w_rnd = '0;
    w_ld  = 1'b0;
    w_re  = 1'b0;
    w_lr  = 1'b0;
    w_dn  = 1'b0;
    w_bs  = 1'b0;
    if (!w_abort) begin
      unique case (1'b1)
        r_state == S_LOAD: begin
          w_ld  = 1'b1;
          w_bs  = 1'b1;
          w_kb  = w_key_ser;
          w_db  = w_data_ser;
          w_idx = r_byte_cnt;
        end
        r_state == S_ROUND: begin
          w_re  = 1'b1;
          w_bs  = 1'b1;
          w_idx = r_byte_cnt;
          w_rnd = r_round;
          w_lr  = w_last_rnd;
        end
        r_state == S_FINISH: begin
          w_dn = 1'b1;
          w_bs = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_kb  <= '0;
      r_db  <= '0;
      r_idx <= '0;
      r_rnd <= '0;
      r_ld  <= 1'b0;
      r_re  <= 1'b0;
      r_lr  <= 1'b0;
      r_dn  <= 1'b0;
      r_bs  <= 1'b0;
    end else begin
      r_kb  <= w_kb;
      r_db  <= w_db;
      r_idx <= w_idx;
      r_rnd <= w_rnd;
      r_ld  <= w_ld;
      r_re  <= w_re;
      r_lr  <= w_lr;
      r_dn  <= w_dn;
      r_bs  <= w_bs;
    end
  end

  assign bus.key_byte   = r_kb;
  assign bus.data_byte  = r_db;
  assign bus.byte_idx   = r_idx;
  assign bus.round      = r_rnd;
  assign bus.load_en    = r_ld;
  assign bus.round_en   = r_re;
  assign bus.last_round = r_lr;
  assign bus.done       = r_dn;
  assign bus.busy       = r_bs;
endmodule
